rs_agu_multi: RTL and testbench

Parametrised address-generation reservation station for the out-of-order core. Accepts up to DISP_W load/store micro-ops per cycle from rename/dispatch and holds them in DEPTH entries. Snoops WAKE_W result-broadcast channels and issues one ready micro-op per cycle to the AGU, oldest-first by ROB age. Unlike the previous generation, stores wait on both the base operand (Pa) and the store-data operand (Pb), a free-slot count is exported, and freeze_back stalls the issue register instead of clearing it.

---
 rtl/rs_agu_multi.sv | 246 ++++++++++++++++++++++++
 tb/tb_rs_agu_multi.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_agu_multi.sv
// rs_agu_multi -- address-generation reservation station.
//
// Takes up to DISP_W load/store micro-ops per cycle from dispatch, parks them
// in DEPTH entries until their operands are ready (base Pa for every op, plus
// store data Pb for stores), snoops WAKE_W result broadcasts, and issues the
// oldest ready op (by ROB age relative to ptr_old) into a one-deep issue
// register feeding the AGU.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     synchronous clear of all entries and the issue register
//   freeze_front              blocks dispatch writes
//   freeze_back               AGU stall: no selection, issue register holds
//   valid_pc, disp_valid      dispatch group valid, per-port op valid
//   is_store, Pa/valid_Pa, Pb/valid_Pb, Imm, tag_ROB   per-port op payload
//   wake_valid, wake_Pw       result-broadcast channels
//   ptr_old                   ROB head tag, reference point for age
//   full_RS, free_cnt         fewer than DISP_W free entries / free entry count
//   *_awake                   issue register contents
module rs_agu_multi #(
  parameter int DEPTH  = 8,
  parameter int DISP_W = 3,
  parameter int WAKE_W = 3,
  parameter int PREG_W = 5,
  parameter int IMM_W  = 5,
  parameter int ROB_W  = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              freeze_front,
  input  logic                              freeze_back,
  input  logic                              valid_pc,
  input  logic [DISP_W-1:0]                 disp_valid,
  input  logic [DISP_W-1:0]                 is_store,
  input  logic [DISP_W-1:0][PREG_W-1:0]     Pa,
  input  logic [DISP_W-1:0]                 valid_Pa,
  input  logic [DISP_W-1:0][PREG_W-1:0]     Pb,
  input  logic [DISP_W-1:0]                 valid_Pb,
  input  logic [DISP_W-1:0][IMM_W-1:0]      Imm,
  input  logic [DISP_W-1:0][ROB_W-1:0]      tag_ROB,
  input  logic [WAKE_W-1:0]                 wake_valid,
  input  logic [WAKE_W-1:0][PREG_W-1:0]     wake_Pw,
  input  logic [ROB_W-1:0]                  ptr_old,
  output logic                              full_RS,
  output logic [$clog2(DEPTH+1)-1:0]        free_cnt,
  output logic                              valid_op_awake,
  output logic                              store_awake,
  output logic [PREG_W-1:0]                 Pa_awake,
  output logic [PREG_W-1:0]                 Pb_awake,
  output logic [IMM_W-1:0]                  Imm_awake,
  output logic [ROB_W-1:0]                  tag_ROB_awake
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Control state (reset) and payload storage (not reset).
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_rdya;
  logic [DEPTH-1:0]  ent_rdyb;
  logic [DEPTH-1:0]  ent_store;
  logic [PREG_W-1:0] ent_pa  [DEPTH];
  logic [PREG_W-1:0] ent_pb  [DEPTH];
  logic [IMM_W-1:0]  ent_imm [DEPTH];
  logic [ROB_W-1:0]  ent_rob [DEPTH];

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] used_cnt;

  // NOTE: every variable assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    used_cnt = '0;
    for (int i = 0; i < DEPTH; i++) used_cnt = used_cnt + CNT_W'(ent_valid[i]);
  end

  assign free_cnt = CNT_W'(DEPTH) - used_cnt;
  assign full_RS  = (int'(free_cnt) < DISP_W);

  logic disp_fire;
  assign disp_fire = valid_pc && !freeze_front && !full_RS && !flush;

  // ---------------------------------------------------------------------------
  // Allocation: the k-th active port takes the k-th lowest free entry.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] avail;
  logic [IDX_W-1:0] alloc_idx [DISP_W];
  logic [DISP_W-1:0] alloc_ok;

  always_comb begin
    avail    = ~ent_valid;
    alloc_ok = '0;
    for (int p = 0; p < DISP_W; p++) begin
      alloc_idx[p] = '0;
      if (disp_valid[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (avail[i] && !alloc_ok[p]) begin
            alloc_idx[p] = IDX_W'(i);
            alloc_ok[p]  = 1'b1;
            avail[i]     = 1'b0;
          end
        end
      end
    end
  end

  // Ready bits at write time, including same-cycle broadcast bypass.
  logic [DISP_W-1:0] rdya_in, rdyb_in;

  always_comb begin
    for (int p = 0; p < DISP_W; p++) begin
      rdya_in[p] = valid_Pa[p];
      rdyb_in[p] = valid_Pb[p];
      for (int j = 0; j < WAKE_W; j++) begin
        if (wake_valid[j] && wake_Pw[j] == Pa[p]) rdya_in[p] = 1'b1;
        if (wake_valid[j] && wake_Pw[j] == Pb[p]) rdyb_in[p] = 1'b1;
      end
      // Loads have no data operand.
      if (!is_store[p]) rdyb_in[p] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Wakeup matches against stored tags
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] hit_a, hit_b;

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < WAKE_W; j++) begin
        if (wake_valid[j] && wake_Pw[j] == ent_pa[i]) hit_a[i] = 1'b1;
        if (wake_valid[j] && wake_Pw[j] == ent_pb[i]) hit_b[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Oldest-first select on registered state. Age wraps modulo 2^ROB_W, so the
  // subtraction is kept at ROB_W bits. Strict '<' keeps the lower index on ties.
  // ---------------------------------------------------------------------------
  logic [ROB_W-1:0] age [DEPTH];
  logic [ROB_W-1:0] best_age;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;

  always_comb begin
    best_age  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      age[i] = ent_rob[i] - ptr_old;
      if (ent_valid[i] && ent_rdya[i] && ent_rdyb[i] &&
          (!sel_found || age[i] < best_age)) begin
        best_age  = age[i];
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control state and issue register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; later assignments in this block override earlier ones for
  // the same bit (dispatch never targets a valid, so it never collides with
  // the wakeup or issue-free updates).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid      <= '0;
      ent_rdya       <= '0;
      ent_rdyb       <= '0;
      valid_op_awake <= 1'b0;
      store_awake    <= 1'b0;
      Pa_awake       <= '0;
      Pb_awake       <= '0;
      Imm_awake      <= '0;
      tag_ROB_awake  <= '0;
    end else if (flush) begin
      ent_valid      <= '0;
      ent_rdya       <= '0;
      ent_rdyb       <= '0;
      valid_op_awake <= 1'b0;
      store_awake    <= 1'b0;
      Pa_awake       <= '0;
      Pb_awake       <= '0;
      Imm_awake      <= '0;
      tag_ROB_awake  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && hit_a[i]) ent_rdya[i] <= 1'b1;
        if (ent_valid[i] && hit_b[i]) ent_rdyb[i] <= 1'b1;
      end

      if (!freeze_back) begin
        valid_op_awake <= sel_found;
        if (sel_found) begin
          store_awake        <= ent_store[sel_idx];
          Pa_awake           <= ent_pa[sel_idx];
          Pb_awake           <= ent_pb[sel_idx];
          Imm_awake          <= ent_imm[sel_idx];
          tag_ROB_awake      <= ent_rob[sel_idx];
          ent_valid[sel_idx] <= 1'b0;
        end else begin
          store_awake   <= 1'b0;
          Pa_awake      <= '0;
          Pb_awake      <= '0;
          Imm_awake     <= '0;
          tag_ROB_awake <= '0;
        end
      end

      if (disp_fire) begin
        for (int p = 0; p < DISP_W; p++) begin
          if (disp_valid[p] && alloc_ok[p]) begin
            ent_valid[alloc_idx[p]] <= 1'b1;
            ent_rdya[alloc_idx[p]]  <= rdya_in[p];
            ent_rdyb[alloc_idx[p]]  <= rdyb_in[p];
          end
        end
      end
    end
  end

  // NOTE: the payload array is deliberately not reset; an entry's fields are
  // only observed while its valid bit is set, and valid is always reset.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      for (int p = 0; p < DISP_W; p++) begin
        if (disp_valid[p] && alloc_ok[p]) begin
          ent_store[alloc_idx[p]] <= is_store[p];
          ent_pa[alloc_idx[p]]    <= Pa[p];
          ent_pb[alloc_idx[p]]    <= Pb[p];
          ent_imm[alloc_idx[p]]   <= Imm[p];
          ent_rob[alloc_idx[p]]   <= tag_ROB[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_agu_multi.sv
// Self-checking bench for rs_agu_multi: directed scenarios with explicit
// expected values, then randomized traffic compared against a behavioural
// model of the station kept as plain arrays.
module tb_rs_agu_multi;

  localparam int DEPTH  = 8;
  localparam int DISP_W = 3;
  localparam int WAKE_W = 3;
  localparam int PREG_W = 5;
  localparam int IMM_W  = 5;
  localparam int ROB_W  = 5;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int ROB_MOD = 1 << ROB_W;

  logic clk = 1'b0;
  logic rst;
  logic flush, freeze_front, freeze_back, valid_pc;
  logic [DISP_W-1:0]             disp_valid, is_store, valid_Pa, valid_Pb;
  logic [DISP_W-1:0][PREG_W-1:0] Pa, Pb;
  logic [DISP_W-1:0][IMM_W-1:0]  Imm;
  logic [DISP_W-1:0][ROB_W-1:0]  tag_ROB;
  logic [WAKE_W-1:0]             wake_valid;
  logic [WAKE_W-1:0][PREG_W-1:0] wake_Pw;
  logic [ROB_W-1:0]              ptr_old;
  logic                          full_RS;
  logic [CNT_W-1:0]              free_cnt;
  logic                          valid_op_awake, store_awake;
  logic [PREG_W-1:0]             Pa_awake, Pb_awake;
  logic [IMM_W-1:0]              Imm_awake;
  logic [ROB_W-1:0]              tag_ROB_awake;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rs_agu_multi #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .WAKE_W(WAKE_W),
    .PREG_W(PREG_W), .IMM_W(IMM_W), .ROB_W(ROB_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze_front(freeze_front),
    .freeze_back(freeze_back), .valid_pc(valid_pc), .disp_valid(disp_valid),
    .is_store(is_store), .Pa(Pa), .valid_Pa(valid_Pa), .Pb(Pb),
    .valid_Pb(valid_Pb), .Imm(Imm), .tag_ROB(tag_ROB),
    .wake_valid(wake_valid), .wake_Pw(wake_Pw), .ptr_old(ptr_old),
    .full_RS(full_RS), .free_cnt(free_cnt), .valid_op_awake(valid_op_awake),
    .store_awake(store_awake), .Pa_awake(Pa_awake), .Pb_awake(Pb_awake),
    .Imm_awake(Imm_awake), .tag_ROB_awake(tag_ROB_awake)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: a set of slots, each either empty or holding an op with
  // two ready flags; one output slot.
  // ---------------------------------------------------------------------------
  bit                m_valid [DEPTH];
  bit                m_store [DEPTH];
  bit                m_ra    [DEPTH];
  bit                m_rb    [DEPTH];
  logic [PREG_W-1:0] m_pa    [DEPTH];
  logic [PREG_W-1:0] m_pb    [DEPTH];
  logic [IMM_W-1:0]  m_imm   [DEPTH];
  logic [ROB_W-1:0]  m_rob   [DEPTH];
  bit                o_valid, o_store;
  logic [PREG_W-1:0] o_pa, o_pb;
  logic [IMM_W-1:0]  o_imm;
  logic [ROB_W-1:0]  o_rob;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_ra[i] = 0; m_rb[i] = 0;
    end
    o_valid = 0; o_store = 0; o_pa = '0; o_pb = '0; o_imm = '0; o_rob = '0;
  endtask

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) n++;
    return n;
  endfunction

  function automatic bit woken(logic [PREG_W-1:0] tag);
    for (int j = 0; j < WAKE_W; j++) if (wake_valid[j] && wake_Pw[j] == tag) return 1;
    return 0;
  endfunction

  // Applies the current inputs to the model as one clock edge.
  task automatic model_step();
    int free_q[$];
    int sel, best, a, k;
    bit fire;
    if (flush) begin
      model_reset();
      return;
    end
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) free_q.push_back(i);
    fire = valid_pc && !freeze_front && (free_q.size() >= DISP_W);
    sel = -1; best = ROB_MOD;
    for (int i = 0; i < DEPTH; i++) begin
      a = (int'(m_rob[i]) - int'(ptr_old) + ROB_MOD) % ROB_MOD;
      if (m_valid[i] && m_ra[i] && m_rb[i] && a < best) begin
        best = a; sel = i;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i]) begin
        if (woken(m_pa[i])) m_ra[i] = 1;
        if (woken(m_pb[i])) m_rb[i] = 1;
      end
    end
    if (!freeze_back) begin
      if (sel >= 0) begin
        o_valid = 1; o_store = m_store[sel]; o_pa = m_pa[sel]; o_pb = m_pb[sel];
        o_imm = m_imm[sel]; o_rob = m_rob[sel];
        m_valid[sel] = 0;
      end else begin
        o_valid = 0; o_store = 0; o_pa = '0; o_pb = '0; o_imm = '0; o_rob = '0;
      end
    end
    if (fire) begin
      k = 0;
      for (int p = 0; p < DISP_W; p++) begin
        if (disp_valid[p]) begin
          int e = free_q[k];
          k++;
          m_valid[e] = 1;
          m_store[e] = is_store[p];
          m_pa[e] = Pa[p]; m_pb[e] = Pb[p]; m_imm[e] = Imm[p]; m_rob[e] = tag_ROB[p];
          m_ra[e] = valid_Pa[p] || woken(Pa[p]);
          m_rb[e] = !is_store[p] || valid_Pb[p] || woken(Pb[p]);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle();
    flush = 0; freeze_front = 0; freeze_back = 0; valid_pc = 0;
    disp_valid = '0; is_store = '0; valid_Pa = '0; valid_Pb = '0;
    Pa = '0; Pb = '0; Imm = '0; tag_ROB = '0;
    wake_valid = '0; wake_Pw = '0;
  endtask

  task automatic set_op(int p, bit st, int pa, bit vpa, int pb, bit vpb, int imm, int rob);
    valid_pc      = 1;
    disp_valid[p] = 1;
    is_store[p]   = st;
    Pa[p]         = PREG_W'(pa);
    valid_Pa[p]   = vpa;
    Pb[p]         = PREG_W'(pb);
    valid_Pb[p]   = vpb;
    Imm[p]        = IMM_W'(imm);
    tag_ROB[p]    = ROB_W'(rob);
  endtask

  // One clock: model and DUT see the same held inputs, outputs sampled 1ns later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle();
    ptr_old = '0;
    rst = 1;
    model_reset();
    #12;
    checks++;
    if ({valid_op_awake, store_awake, Pa_awake, Pb_awake, Imm_awake, tag_ROB_awake} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b st=%0b pa=%0d pb=%0d imm=%0d rob=%0d want all 0",
               valid_op_awake, store_awake, Pa_awake, Pb_awake, Imm_awake, tag_ROB_awake);
    end
    checks++;
    if (free_cnt !== CNT_W'(8) || full_RS !== 1'b0) begin
      errors++;
      $display("FAIL reset_occupancy got free=%0d full=%0b want free=8 full=0", free_cnt, full_RS);
    end
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_load_order();
    int exp_rob[3] = '{4, 5, 6};
    int exp_free[3] = '{6, 7, 8};
    idle();
    set_op(0, 0, 1, 1, 0, 0, 11, 4);
    set_op(1, 0, 2, 1, 0, 0, 12, 5);
    set_op(2, 0, 3, 1, 0, 0, 13, 6);
    cycle();
    idle();
    checks++;
    if (free_cnt !== CNT_W'(5) || valid_op_awake !== 1'b0) begin
      errors++;
      $display("FAIL load_alloc got free=%0d v=%0b want free=5 v=0", free_cnt, valid_op_awake);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if ({valid_op_awake, store_awake, tag_ROB_awake, Pa_awake, Imm_awake} !==
          {1'b1, 1'b0, ROB_W'(exp_rob[k]), PREG_W'(k + 1), IMM_W'(11 + k)} ||
          free_cnt !== CNT_W'(exp_free[k])) begin
        errors++;
        $display("FAIL load_issue_%0d got v=%0b rob=%0d pa=%0d imm=%0d free=%0d want v=1 rob=%0d pa=%0d imm=%0d free=%0d",
                 k, valid_op_awake, tag_ROB_awake, Pa_awake, Imm_awake, free_cnt,
                 exp_rob[k], k + 1, 11 + k, exp_free[k]);
      end
    end
    cycle();
    checks++;
    if (valid_op_awake !== 1'b0 || tag_ROB_awake !== '0 || free_cnt !== CNT_W'(8)) begin
      errors++;
      $display("FAIL load_drain got v=%0b rob=%0d free=%0d want v=0 rob=0 free=8",
               valid_op_awake, tag_ROB_awake, free_cnt);
    end
  endtask

  task automatic test_store_wake();
    idle();
    set_op(0, 1, 3, 1, 9, 0, 21, 7);
    cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (valid_op_awake !== 1'b0) begin
        errors++;
        $display("FAIL store_wait_%0d got v=%0b want v=0", k, valid_op_awake);
      end
    end
    wake_valid[2] = 1; wake_Pw[2] = PREG_W'(9);
    cycle();
    idle();
    checks++;
    if (valid_op_awake !== 1'b0) begin
      errors++;
      $display("FAIL store_wake_edge got v=%0b want v=0", valid_op_awake);
    end
    cycle();
    checks++;
    if ({valid_op_awake, store_awake, Pa_awake, Pb_awake, Imm_awake, tag_ROB_awake} !==
        {1'b1, 1'b1, PREG_W'(3), PREG_W'(9), IMM_W'(21), ROB_W'(7)}) begin
      errors++;
      $display("FAIL store_issue got v=%0b st=%0b pa=%0d pb=%0d imm=%0d rob=%0d want v=1 st=1 pa=3 pb=9 imm=21 rob=7",
               valid_op_awake, store_awake, Pa_awake, Pb_awake, Imm_awake, tag_ROB_awake);
    end
    cycle();
  endtask

  task automatic test_bypass();
    idle();
    set_op(0, 0, 7, 0, 0, 0, 5, 8);
    wake_valid[0] = 1; wake_Pw[0] = PREG_W'(7);
    cycle();
    idle();
    checks++;
    if (valid_op_awake !== 1'b0 || free_cnt !== CNT_W'(7)) begin
      errors++;
      $display("FAIL bypass_alloc got v=%0b free=%0d want v=0 free=7", valid_op_awake, free_cnt);
    end
    cycle();
    checks++;
    if ({valid_op_awake, Pa_awake, tag_ROB_awake} !== {1'b1, PREG_W'(7), ROB_W'(8)}) begin
      errors++;
      $display("FAIL bypass_issue got v=%0b pa=%0d rob=%0d want v=1 pa=7 rob=8",
               valid_op_awake, Pa_awake, tag_ROB_awake);
    end
    cycle();
  endtask

  task automatic test_age_wrap();
    int exp_rob[3] = '{31, 1, 29};
    idle();
    ptr_old = ROB_W'(30);
    set_op(0, 0, 1, 1, 0, 0, 0, 31);
    set_op(1, 0, 2, 1, 0, 0, 0, 1);
    set_op(2, 0, 3, 1, 0, 0, 0, 29);
    cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (valid_op_awake !== 1'b1 || tag_ROB_awake !== ROB_W'(exp_rob[k])) begin
        errors++;
        $display("FAIL age_order_%0d got v=%0b rob=%0d want v=1 rob=%0d",
                 k, valid_op_awake, tag_ROB_awake, exp_rob[k]);
      end
    end
    ptr_old = '0;
    cycle();
  endtask

  task automatic test_full();
    int guard;
    idle();
    freeze_back = 1;
    for (int p = 0; p < 3; p++) set_op(p, 0, p, 1, 0, 0, 0, p);
    cycle();
    for (int p = 0; p < 3; p++) set_op(p, 0, p, 1, 0, 0, 0, p + 3);
    cycle();
    checks++;
    if (free_cnt !== CNT_W'(2) || full_RS !== 1'b1) begin
      errors++;
      $display("FAIL full_set got free=%0d full=%0b want free=2 full=1", free_cnt, full_RS);
    end
    for (int p = 0; p < 3; p++) set_op(p, 0, p, 1, 0, 0, 0, p + 6);
    cycle();
    checks++;
    if (free_cnt !== CNT_W'(2) || full_RS !== 1'b1) begin
      errors++;
      $display("FAIL full_blocks got free=%0d full=%0b want free=2 full=1", free_cnt, full_RS);
    end
    idle();
    cycle();
    checks++;
    if (free_cnt !== CNT_W'(3) || full_RS !== 1'b0 || valid_op_awake !== 1'b1 ||
        tag_ROB_awake !== ROB_W'(0)) begin
      errors++;
      $display("FAIL full_release got free=%0d full=%0b v=%0b rob=%0d want free=3 full=0 v=1 rob=0",
               free_cnt, full_RS, valid_op_awake, tag_ROB_awake);
    end
    guard = 0;
    while (free_cnt !== CNT_W'(8) && guard < 20) begin
      cycle();
      guard++;
    end
    checks++;
    if (free_cnt !== CNT_W'(8) || tag_ROB_awake !== ROB_W'(5)) begin
      errors++;
      $display("FAIL full_drain got free=%0d last_rob=%0d want free=8 last_rob=5",
               free_cnt, tag_ROB_awake);
    end
    cycle();
  endtask

  task automatic test_freeze_flush();
    idle();
    set_op(0, 0, 4, 1, 0, 0, 1, 10);
    set_op(1, 0, 5, 1, 0, 0, 2, 11);
    set_op(2, 0, 6, 1, 0, 0, 3, 12);
    cycle();
    idle();
    cycle();
    freeze_back = 1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if ({valid_op_awake, tag_ROB_awake, Pa_awake, Imm_awake} !==
          {1'b1, ROB_W'(10), PREG_W'(4), IMM_W'(1)} || free_cnt !== CNT_W'(6)) begin
        errors++;
        $display("FAIL freeze_hold_%0d got v=%0b rob=%0d pa=%0d imm=%0d free=%0d want v=1 rob=10 pa=4 imm=1 free=6",
                 k, valid_op_awake, tag_ROB_awake, Pa_awake, Imm_awake, free_cnt);
      end
    end
    freeze_back = 0;
    flush = 1;
    cycle();
    idle();
    checks++;
    if (valid_op_awake !== 1'b0 || tag_ROB_awake !== '0 || free_cnt !== CNT_W'(8)) begin
      errors++;
      $display("FAIL flush_clear got v=%0b rob=%0d free=%0d want v=0 rob=0 free=8",
               valid_op_awake, tag_ROB_awake, free_cnt);
    end
  endtask

  task automatic test_async_reset();
    idle();
    set_op(0, 0, 1, 1, 0, 0, 3, 2);
    set_op(1, 1, 2, 1, 3, 0, 4, 3);
    cycle();
    idle();
    cycle();
    #2 rst = 1;
    #1;
    model_reset();
    checks++;
    if (valid_op_awake !== 1'b0 || tag_ROB_awake !== '0 || free_cnt !== CNT_W'(8) || full_RS !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%0b rob=%0d free=%0d full=%0b want v=0 rob=0 free=8 full=0",
               valid_op_awake, tag_ROB_awake, free_cnt, full_RS);
    end
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush        = ($urandom_range(0, 39) == 0);
      freeze_front = ($urandom_range(0, 5) == 0);
      freeze_back  = ($urandom_range(0, 4) == 0);
      valid_pc     = ($urandom_range(0, 2) != 0);
      disp_valid   = DISP_W'($urandom);
      is_store     = DISP_W'($urandom);
      valid_Pa     = DISP_W'($urandom);
      valid_Pb     = DISP_W'($urandom);
      for (int p = 0; p < DISP_W; p++) begin
        Pa[p]      = PREG_W'($urandom_range(0, 7));
        Pb[p]      = PREG_W'($urandom_range(0, 7));
        Imm[p]     = IMM_W'($urandom);
        tag_ROB[p] = ROB_W'($urandom);
      end
      for (int j = 0; j < WAKE_W; j++) begin
        wake_valid[j] = ($urandom_range(0, 3) == 0);
        wake_Pw[j]    = PREG_W'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) ptr_old = ROB_W'($urandom);
      cycle();
      checks++;
      if ({valid_op_awake, store_awake, Pa_awake, Pb_awake, Imm_awake, tag_ROB_awake} !==
          {o_valid, o_store, o_pa, o_pb, o_imm, o_rob}) begin
        errors++;
        $display("FAIL rand_issue_c%0d got v=%0b st=%0b pa=%0d pb=%0d imm=%0d rob=%0d want v=%0b st=%0b pa=%0d pb=%0d imm=%0d rob=%0d",
                 c, valid_op_awake, store_awake, Pa_awake, Pb_awake, Imm_awake, tag_ROB_awake,
                 o_valid, o_store, o_pa, o_pb, o_imm, o_rob);
      end
      checks++;
      if (free_cnt !== CNT_W'(model_free()) || full_RS !== (model_free() < DISP_W)) begin
        errors++;
        $display("FAIL rand_occ_c%0d got free=%0d full=%0b want free=%0d full=%0b",
                 c, free_cnt, full_RS, model_free(), model_free() < DISP_W);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_order();
    test_store_wake();
    test_bypass();
    test_age_wrap();
    test_full();
    test_freeze_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
